// File: rtl/mine_neighbour_counter_if.sv
`default_nettype none
// =====================================================================
// Module  : mine_neighbour_counter_if
// Brief   : cell handshake, mine-map read port and number-map write port
// Rev     : 1.0 initial release
// =====================================================================
interface mine_neighbour_counter_if #(
  parameter int COORD_W = 5
);
  logic               cell_valid;
  logic [COORD_W-1:0] cell_x;
  logic [COORD_W-1:0] cell_y;
  logic               cell_ready;
  logic               mine_rd_en;
  logic [COORD_W-1:0] mine_rd_x;
  logic [COORD_W-1:0] mine_rd_y;
  logic               mine_rd_data;
  logic               cnt_wr_en;
  logic [COORD_W-1:0] cnt_wr_x;
  logic [COORD_W-1:0] cnt_wr_y;
  logic [3:0]         cnt_wr_data;

  // master = the counter block, slave = scanner plus map memories
  modport master (
    input  cell_valid, cell_x, cell_y, mine_rd_data,
    output cell_ready, mine_rd_en, mine_rd_x, mine_rd_y,
           cnt_wr_en, cnt_wr_x, cnt_wr_y, cnt_wr_data
  );
  modport slave (
    output cell_valid, cell_x, cell_y, mine_rd_data,
    input  cell_ready, mine_rd_en, mine_rd_x, mine_rd_y,
           cnt_wr_en, cnt_wr_x, cnt_wr_y, cnt_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/mine_neighbour_counter.sv
`default_nettype none
// =====================================================================
// Module  : mine_neighbour_counter
// Brief   : reads the 8 neighbours of each accepted cell and writes the
//           adjacent-mine count; MNC_SELF_MARK_EN adds a centre read
// Rev     : 1.0 initial release
// =====================================================================
module mine_neighbour_counter #(
  parameter int         COORD_W   = 5,
  parameter logic [3:0] MINE_CODE = 4'hF
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               clear,
  input  wire logic [COORD_W-1:0] dimension_size,
  mine_neighbour_counter_if.master bus,
  output logic                    busy,
  output logic [9:0]              cells_done
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_WRITE = 2'd3
  } state_t;

`ifdef MNC_SELF_MARK_EN
  localparam logic [3:0] c_LAST_SLOT = 4'd8;
`else
  localparam logic [3:0] c_LAST_SLOT = 4'd7;
  wire logic [3:0] w_unused_code = MINE_CODE;
`endif
  localparam logic [COORD_W-1:0] c_ONE      = 1;
  localparam logic [9:0]         c_DONE_MAX = 10'h3FF;

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_slot, w_slot_nxt, w_issue_slot;
  logic [COORD_W-1:0] r_x, r_y, r_dim, w_x_nxt, w_y_nxt, w_dim_nxt;
  logic [COORD_W-1:0] w_base_x, w_base_y, w_base_dim, w_nx, w_ny;
  logic [1:0]         w_dx, w_dy;
  logic               w_ok_x, w_ok_y, w_issue, w_hit;
  logic [3:0]         r_acc, w_acc_nxt;
  logic               r_rd_en_d;
  logic               r_ready, r_busy;
  logic               r_rd_en, w_rd_en_nxt;
  logic [COORD_W-1:0] r_rd_x, r_rd_y, w_rd_x_nxt, w_rd_y_nxt;
  logic               r_wr_en, w_wr_en_nxt;
  logic [COORD_W-1:0] r_wr_x, r_wr_y, w_wr_x_nxt, w_wr_y_nxt;
  logic [3:0]         r_wr_data, w_wr_data_nxt;
  logic [9:0]         r_done, w_done_nxt;

  // Slot 0 is issued straight from the inputs in the acceptance cycle.
  assign w_base_x     = (r_state == S_IDLE) ? bus.cell_x     : r_x;
  assign w_base_y     = (r_state == S_IDLE) ? bus.cell_y     : r_y;
  assign w_base_dim   = (r_state == S_IDLE) ? dimension_size : r_dim;
  assign w_issue_slot = (r_state == S_IDLE) ? 4'd0 : r_slot + 4'd1;
  assign w_hit        = r_rd_en_d & bus.mine_rd_data;

  // Offset codes: 0 = -1, 1 = 0, 2 = +1
  always_comb begin
    w_dx = 2'd1;
    w_dy = 2'd1;
    case (w_issue_slot)
      4'd0:    begin w_dx = 2'd0; w_dy = 2'd0; end
      4'd1:    begin w_dx = 2'd1; w_dy = 2'd0; end
      4'd2:    begin w_dx = 2'd2; w_dy = 2'd0; end
      4'd3:    begin w_dx = 2'd0; w_dy = 2'd1; end
      4'd4:    begin w_dx = 2'd2; w_dy = 2'd1; end
      4'd5:    begin w_dx = 2'd0; w_dy = 2'd2; end
      4'd6:    begin w_dx = 2'd1; w_dy = 2'd2; end
      4'd7:    begin w_dx = 2'd2; w_dy = 2'd2; end
      default: begin w_dx = 2'd1; w_dy = 2'd1; end
    endcase
    w_ok_x = 1'b1;
    w_nx   = w_base_x;
    if (w_dx == 2'd0) begin
      w_ok_x = (w_base_x != '0);
      w_nx   = w_base_x - c_ONE;
    end else if (w_dx == 2'd2) begin
      w_ok_x = (w_base_x < w_base_dim);
      w_nx   = w_base_x + c_ONE;
    end
    w_ok_y = 1'b1;
    w_ny   = w_base_y;
    if (w_dy == 2'd0) begin
      w_ok_y = (w_base_y != '0);
      w_ny   = w_base_y - c_ONE;
    end else if (w_dy == 2'd2) begin
      w_ok_y = (w_base_y < w_base_dim);
      w_ny   = w_base_y + c_ONE;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_slot_nxt    = r_slot;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_dim_nxt     = r_dim;
    w_acc_nxt     = r_acc + {3'b000, w_hit};
    w_issue       = 1'b0;
    w_rd_en_nxt   = 1'b0;
    w_rd_x_nxt    = r_rd_x;
    w_rd_y_nxt    = r_rd_y;
    w_wr_en_nxt   = 1'b0;
    w_wr_x_nxt    = r_wr_x;
    w_wr_y_nxt    = r_wr_y;
    w_wr_data_nxt = r_wr_data;
    w_done_nxt    = r_done;
    case (r_state)
      S_IDLE: begin
        if (bus.cell_valid) begin
          w_x_nxt   = bus.cell_x;
          w_y_nxt   = bus.cell_y;
          w_dim_nxt = dimension_size;
          w_acc_nxt = '0;
          if ((dimension_size != '0) && (bus.cell_x <= dimension_size) &&
              (bus.cell_y <= dimension_size)) begin
            w_state_nxt = S_SCAN;
            w_slot_nxt  = '0;
            w_issue     = 1'b1;
          end
        end
      end
      S_SCAN: begin
        if (r_slot == c_LAST_SLOT) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_slot_nxt = r_slot + 4'd1;
          w_issue    = 1'b1;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_WRITE;
        w_wr_en_nxt = 1'b1;
        w_wr_x_nxt  = r_x;
        w_wr_y_nxt  = r_y;
`ifdef MNC_SELF_MARK_EN
        // The sample landing in DRAIN is the centre cell, not a neighbour.
        w_acc_nxt     = r_acc;
        w_wr_data_nxt = w_hit ? MINE_CODE : r_acc;
`else
        w_wr_data_nxt = w_acc_nxt;
`endif
      end
      S_WRITE: begin
        w_state_nxt = S_IDLE;
        if (r_done != c_DONE_MAX) w_done_nxt = r_done + 10'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_issue) begin
      w_rd_en_nxt = w_ok_x & w_ok_y;
      if (w_ok_x & w_ok_y) begin
        w_rd_x_nxt = w_nx;
        w_rd_y_nxt = w_ny;
      end
    end
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_slot_nxt  = '0;
      w_rd_en_nxt = 1'b0;
      w_wr_en_nxt = 1'b0;
      w_done_nxt  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_slot    <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_dim     <= '0;
      r_acc     <= '0;
      r_rd_en_d <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_x    <= '0;
      r_rd_y    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_x    <= '0;
      r_wr_y    <= '0;
      r_wr_data <= '0;
      r_done    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_slot    <= w_slot_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_dim     <= w_dim_nxt;
      r_acc     <= w_acc_nxt;
      r_rd_en_d <= r_rd_en & ~clear;
      r_ready   <= (w_state_nxt == S_IDLE);
      r_busy    <= (w_state_nxt != S_IDLE);
      r_rd_en   <= w_rd_en_nxt;
      r_rd_x    <= w_rd_x_nxt;
      r_rd_y    <= w_rd_y_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_x    <= w_wr_x_nxt;
      r_wr_y    <= w_wr_y_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign bus.cell_ready  = r_ready;
  assign bus.mine_rd_en  = r_rd_en;
  assign bus.mine_rd_x   = r_rd_x;
  assign bus.mine_rd_y   = r_rd_y;
  assign bus.cnt_wr_en   = r_wr_en;
  assign bus.cnt_wr_x    = r_wr_x;
  assign bus.cnt_wr_y    = r_wr_y;
  assign bus.cnt_wr_data = r_wr_data;
  assign busy            = r_busy;
  assign cells_done      = r_done;
endmodule
`default_nettype wire
